bmp_input_frontend: RTL

Parametrised input front end for the rotation datapath. It synchronises the testbench BMP stream (Start_in, H_Valid_in, H_Jump_in, Bmp_Data) through a configurable register pipeline and tags every pixel with its x/y position and frame/line markers. Tagged pixels are buffered in a FIFO and delivered to the rotation core over a valid/ready handshake, with overflow and line-length error reporting.

---
 rtl/bmp_input_frontend_if.sv | 26 ++
 rtl/bmp_input_frontend.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_input_frontend_if.sv
// Tagged-pixel stream from the BMP input front end to the rotation core.
// master = producer (front end), slave = consumer (rotation core).
interface bmp_input_frontend_if #(
    parameter int PIXEL_W = 24,
    parameter int XW      = 10,
    parameter int YW      = 10
);
    logic               pix_valid;
    logic               pix_ready;
    logic [PIXEL_W-1:0] pix_data;
    logic [XW-1:0]      pix_x;
    logic [YW-1:0]      pix_y;
    logic               pix_sof;
    logic               pix_eol;
    logic               pix_eof;

    modport master (
        output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/bmp_input_frontend.sv
// BMP input front end: synchronises the incoming pixel stream, tags each
// pixel with x/y and frame/line markers, and buffers it in a FIFO towards
// the rotation core.
// Optional macro INPUT_LINE_CHECK_EN: mid-line H_Jump sets line_err and
// resynchronises the line counters; without it H_Jump is ignored.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for a start edge; W/H latched when it arrives
// ST_ACTIVE | tagging incoming pixels at the current (x,y)
// ST_DRAIN  | frame complete; waiting for the FIFO to empty
module bmp_input_frontend #(
    parameter int PIXEL_W     = 24,
    parameter int MAX_W       = 1024,
    parameter int MAX_H       = 1024,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    localparam int XW = $clog2(MAX_W),
    localparam int YW = $clog2(MAX_H)
) (
    input  logic                  Clk_in,
    input  logic                  Rst_n_in,
    input  logic                  Start_in,
    input  logic                  H_Valid_in,
    input  logic                  H_Jump_in,
    input  logic [PIXEL_W-1:0]    Bmp_Data,
    input  logic [XW:0]           Img_Width_in,
    input  logic [YW:0]           Img_Height_in,
    bmp_input_frontend_if.master  pix,
    output logic                  frame_busy,
    output logic                  frame_done,
    output logic                  overflow,
    output logic                  line_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = PIXEL_W + XW + YW + 3;
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [XW-1:0] X_ONE   = XW'(1);
    localparam logic [YW-1:0] Y_ONE   = YW'(1);
    localparam logic [XW:0]   W_ONE   = (XW+1)'(1);
    localparam logic [YW:0]   H_ONE   = (YW+1)'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN} state_t;

    logic [SYNC_STAGES-1:0] r_sync_start, r_sync_valid, r_sync_jump;
    logic [PIXEL_W-1:0]     r_sync_data [SYNC_STAGES];
    logic                   w_s_start, w_s_valid, w_s_jump;
    logic [PIXEL_W-1:0]     w_s_data;
    logic                   r_start_prev, r_start_edge;

    state_t                 r_state, w_state_next;
    logic [XW:0]            r_w, w_w_next;
    logic [YW:0]            r_h, w_h_next;
    logic [XW-1:0]          r_x, w_x_next;
    logic [YW-1:0]          r_y, w_y_next;
    logic                   r_tag_valid, w_tag_valid_next;
    logic [EW-1:0]          r_tag_word, w_tag_word_next;
    logic                   w_sof, w_eol, w_eof;
    logic                   w_clear_flags, w_done_next;
    logic                   r_overflow, r_frame_done;

    logic [EW-1:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [AW:0]            r_count, w_cnt_next;
    logic                   w_pop, w_push_ok, w_drop;
    logic [PIXEL_W-1:0]     w_h_data;
    logic [XW-1:0]          w_h_x;
    logic [YW-1:0]          w_h_y;
    logic                   w_h_sof, w_h_eol, w_h_eof, w_valid;

    assign w_s_start = r_sync_start[SYNC_STAGES-1];
    assign w_s_valid = r_sync_valid[SYNC_STAGES-1];
    assign w_s_jump  = r_sync_jump[SYNC_STAGES-1];
    assign w_s_data  = r_sync_data[SYNC_STAGES-1];

    // Input synchroniser chain plus registered start-edge detect.
    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            r_sync_start <= '0;
            r_sync_valid <= '0;
            r_sync_jump  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) r_sync_data[i] <= '0;
            r_start_prev <= 1'b0;
            r_start_edge <= 1'b0;
        end else begin
            r_sync_start[0] <= Start_in;
            r_sync_valid[0] <= H_Valid_in;
            r_sync_jump[0]  <= H_Jump_in;
            r_sync_data[0]  <= Bmp_Data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync_start[i] <= r_sync_start[i-1];
                r_sync_valid[i] <= r_sync_valid[i-1];
                r_sync_jump[i]  <= r_sync_jump[i-1];
                r_sync_data[i]  <= r_sync_data[i-1];
            end
            r_start_prev <= w_s_start;
            r_start_edge <= w_s_start & ~r_start_prev;
        end
    end

    assign w_sof = (r_x == '0) && (r_y == '0);
    assign w_eol = ({1'b0, r_x} == (r_w - W_ONE));
    assign w_eof = w_eol && ({1'b0, r_y} == (r_h - H_ONE));

`ifdef INPUT_LINE_CHECK_EN
    logic w_line_err_set;
`else
    logic w_unused;
    assign w_unused = w_s_jump;
`endif

    // Next-state, position counters and pixel tagging.
    always_comb begin
        w_state_next     = r_state;
        w_w_next         = r_w;
        w_h_next         = r_h;
        w_x_next         = r_x;
        w_y_next         = r_y;
        w_tag_valid_next = 1'b0;
        w_tag_word_next  = r_tag_word;
        w_clear_flags    = 1'b0;
        w_done_next      = 1'b0;
`ifdef INPUT_LINE_CHECK_EN
        w_line_err_set   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (r_start_edge) begin
                    w_w_next      = Img_Width_in;
                    w_h_next      = Img_Height_in;
                    w_x_next      = '0;
                    w_y_next      = '0;
                    w_clear_flags = 1'b1;
                    w_state_next  = ((Img_Width_in == '0) || (Img_Height_in == '0))
                                    ? ST_DRAIN : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_s_valid) begin
                    w_tag_valid_next = 1'b1;
                    w_tag_word_next  = {w_s_data, r_x, r_y, w_sof, w_eol, w_eof};
                    if (w_eol) begin
                        w_x_next = '0;
                        w_y_next = r_y + Y_ONE;
                    end else begin
                        w_x_next = r_x + X_ONE;
                    end
                    if (w_eof) w_state_next = ST_DRAIN;
                end
`ifdef INPUT_LINE_CHECK_EN
                // Jump is judged against x after any same-cycle pixel.
                if (w_s_jump && (w_x_next != '0)) begin
                    w_line_err_set = 1'b1;
                    if ({1'b0, w_y_next} == (r_h - H_ONE)) w_state_next = ST_DRAIN;
                    w_x_next = '0;
                    w_y_next = w_y_next + Y_ONE;
                end
`endif
            end
            ST_DRAIN: begin
                if ((w_cnt_next == '0) && !r_tag_valid) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM state, frame geometry, tag stage and sticky overflow.
    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            r_state      <= ST_IDLE;
            r_w          <= '0;
            r_h          <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_tag_valid  <= 1'b0;
            r_tag_word   <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_w          <= w_w_next;
            r_h          <= w_h_next;
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            r_tag_valid  <= w_tag_valid_next;
            r_tag_word   <= w_tag_word_next;
            r_frame_done <= w_done_next;
            if (w_clear_flags)  r_overflow <= 1'b0;
            else if (w_drop)    r_overflow <= 1'b1;
        end
    end

`ifdef INPUT_LINE_CHECK_EN
    logic r_line_err;
    // Sticky mid-line jump flag.
    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in)           r_line_err <= 1'b0;
        else if (w_clear_flags)  r_line_err <= 1'b0;
        else if (w_line_err_set) r_line_err <= 1'b1;
    end
    assign line_err = r_line_err;
`else
    assign line_err = 1'b0;
`endif

    // A push into a full FIFO still lands when the head leaves the same cycle.
    assign w_pop     = (r_count != '0) && pix.pix_ready;
    assign w_push_ok = r_tag_valid && ((r_count < DEPTH_C) || w_pop);
    assign w_drop    = r_tag_valid && !w_push_ok;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_cnt_next = r_count;
        if (w_push_ok && !w_pop)      w_cnt_next = r_count + CNT_ONE;
        else if (!w_push_ok && w_pop) w_cnt_next = r_count - CNT_ONE;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= w_cnt_next;
        end
    end

    // FIFO storage; contents are only visible when the head is valid.
    always_ff @(posedge Clk_in) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= r_tag_word;
    end

    assign {w_h_data, w_h_x, w_h_y, w_h_sof, w_h_eol, w_h_eof} = r_mem[r_rd_ptr];
    assign w_valid       = (r_count != '0);
    assign pix.pix_valid = w_valid;
    assign pix.pix_data  = w_valid ? w_h_data : '0;
    assign pix.pix_x     = w_valid ? w_h_x    : '0;
    assign pix.pix_y     = w_valid ? w_h_y    : '0;
    assign pix.pix_sof   = w_valid & w_h_sof;
    assign pix.pix_eol   = w_valid & w_h_eol;
    assign pix.pix_eof   = w_valid & w_h_eof;

    assign frame_busy = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
endmodule
